writeback_stage: RTL and testbench

//   MEM/WB pipeline register plus writeback datapath. Captures MEM-stage results on each clock,

---
 rtl/writeback_stage.sv | 127 ++++++++++++
 tb/tb_writeback_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load-data extraction, result-source selection,
// r0 write suppression and a retired-instruction counter.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallW,
  input  logic              flushW,
  input  logic              validM,
  input  logic              regWriteM,
  input  logic [ADDR_W-1:0] writeRegAddrM,
  input  logic [1:0]        resultSrcM,
  input  logic [2:0]        loadTypeM,
  input  logic [DATA_W-1:0] aluResultM,
  input  logic [DATA_W-1:0] readDataM,
  input  logic [DATA_W-1:0] pcPlus8M,
  output logic              Regfile_weW,
  output logic [ADDR_W-1:0] writeRegAddrW,
  output logic [DATA_W-1:0] writeDataW,
  output logic              validW,
  output logic [CNT_W-1:0]  retireCountW
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_LINK = 2'b10,
    SRC_RSVD = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_H  = 3'b001,
    LD_HU = 3'b010,
    LD_B  = 3'b011,
    LD_BU = 3'b100
  } load_type_e;

  logic              r_valid;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_src;
  logic [2:0]        r_load_type;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_read;
  logic [DATA_W-1:0] r_pc8;
  logic [CNT_W-1:0]  r_count;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_result;

  // Flush clears the slot to a zeroed bubble; stall holds everything, including the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_addr      <= '0;
      r_src       <= '0;
      r_load_type <= '0;
      r_alu       <= '0;
      r_read      <= '0;
      r_pc8       <= '0;
      r_count     <= '0;
    end else if (flushW) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_addr      <= '0;
      r_src       <= '0;
      r_load_type <= '0;
      r_alu       <= '0;
      r_read      <= '0;
      r_pc8       <= '0;
    end else if (!stallW) begin
      r_valid     <= validM;
      r_reg_write <= regWriteM;
      r_addr      <= writeRegAddrM;
      r_src       <= resultSrcM;
      r_load_type <= loadTypeM;
      r_alu       <= aluResultM;
      r_read      <= readDataM;
      r_pc8       <= pcPlus8M;
      if (validM) r_count <= r_count + CNT_W'(1);
    end
  end

  // Little-endian lane selection from the low address bits of the effective address.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_byte = r_read[7:0];
    case (r_alu[1:0])
      2'd1:    w_byte = r_read[15:8];
      2'd2:    w_byte = r_read[23:16];
      2'd3:    w_byte = r_read[31:24];
      default: w_byte = r_read[7:0];
    endcase
    w_half = r_alu[1] ? r_read[31:16] : r_read[15:0];

    w_load = r_read;
    case (r_load_type)
      LD_H:    w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      LD_HU:   w_load = {{(DATA_W-16){1'b0}}, w_half};
      LD_B:    w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_BU:   w_load = {{(DATA_W-8){1'b0}}, w_byte};
      default: w_load = r_read;
    endcase

    w_result = r_alu;
    case (r_src)
      SRC_LOAD: w_result = w_load;
      SRC_LINK: w_result = r_pc8;
      default:  w_result = r_alu;
    endcase
  end

  assign Regfile_weW   = r_valid & r_reg_write & (r_addr != '0);
  assign writeRegAddrW = r_addr;
  assign writeDataW    = w_result;
  assign validW        = r_valid;
  assign retireCountW  = r_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases then randomized traffic
// against a behavioural model; a narrow-counter instance exercises counter wrap.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallW, flushW, validM, regWriteM;
  logic [4:0]  writeRegAddrM;
  logic [1:0]  resultSrcM;
  logic [2:0]  loadTypeM;
  logic [31:0] aluResultM, readDataM, pcPlus8M;

  logic        Regfile_weW, validW;
  logic [4:0]  writeRegAddrW;
  logic [31:0] writeDataW, retireCountW;

  logic        s_we, s_valid;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic [3:0]  s_count;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .stallW(stallW), .flushW(flushW), .validM(validM),
    .regWriteM(regWriteM), .writeRegAddrM(writeRegAddrM), .resultSrcM(resultSrcM),
    .loadTypeM(loadTypeM), .aluResultM(aluResultM), .readDataM(readDataM),
    .pcPlus8M(pcPlus8M), .Regfile_weW(Regfile_weW), .writeRegAddrW(writeRegAddrW),
    .writeDataW(writeDataW), .validW(validW), .retireCountW(retireCountW)
  );

  writeback_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .stallW(stallW), .flushW(flushW), .validM(validM),
    .regWriteM(regWriteM), .writeRegAddrM(writeRegAddrM), .resultSrcM(resultSrcM),
    .loadTypeM(loadTypeM), .aluResultM(aluResultM), .readDataM(readDataM),
    .pcPlus8M(pcPlus8M), .Regfile_weW(s_we), .writeRegAddrW(s_addr),
    .writeDataW(s_data), .validW(s_valid), .retireCountW(s_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the WB slot: what instruction is sitting there and how many were accepted.
  logic        m_valid, m_rw;
  logic [4:0]  m_addr;
  logic [1:0]  m_src;
  logic [2:0]  m_lt;
  logic [31:0] m_alu, m_rd, m_pc8, m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] lt, input logic [31:0] word,
                                             input logic [1:0] a);
    logic [31:0] b, h;
    b = (word >> (8 * a)) & 32'hFF;
    h = (word >> (16 * a[1])) & 32'hFFFF;
    case (lt)
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] exp_data();
    if (m_src == 2'd1) return load_value(m_lt, m_rd, m_alu[1:0]);
    if (m_src == 2'd2) return m_pc8;
    return m_alu;
  endfunction

  task automatic model_clear_slot();
    m_valid = 0; m_rw = 0; m_addr = 0; m_src = 0; m_lt = 0;
    m_alu = 0; m_rd = 0; m_pc8 = 0;
  endtask

  task automatic model_reset();
    model_clear_slot();
    m_count = 0;
  endtask

  task automatic model_step();
    if (!rst_n) model_reset();
    else if (flushW) model_clear_slot();
    else if (!stallW) begin
      m_valid = validM; m_rw = regWriteM; m_addr = writeRegAddrM; m_src = resultSrcM;
      m_lt = loadTypeM; m_alu = aluResultM; m_rd = readDataM; m_pc8 = pcPlus8M;
      if (validM) m_count = m_count + 1;
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] a, input logic [1:0] src,
                       input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc8, input logic stall, input logic flush);
    validM = v; regWriteM = rw; writeRegAddrM = a; resultSrcM = src; loadTypeM = lt;
    aluResultM = alu; readDataM = rd; pcPlus8M = pc8; stallW = stall; flushW = flush;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".we"},    {31'd0, Regfile_weW}, {31'd0, (m_valid && m_rw && m_addr != 0)});
    check({tag, ".addr"},  {27'd0, writeRegAddrW}, {27'd0, m_addr});
    check({tag, ".data"},  writeDataW, exp_data());
    check({tag, ".valid"}, {31'd0, validW}, {31'd0, m_valid});
    check({tag, ".count"}, retireCountW, m_count);
    check({tag, ".cnt4"},  {28'd0, s_count}, {28'd0, m_count[3:0]});
  endtask

  localparam logic [31:0] LOAD_WORD = 32'h80FF_7F01;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    check("reset.data_lit", writeDataW, 32'h0);
    check("reset.count_lit", retireCountW, 32'h0);
    rst_n = 1'b1;

    // ALU path
    drive(1, 1, 5'd5, 2'b00, 3'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 0, 0);
    cycle();
    check_all("alu");
    check("alu.we_lit", {31'd0, Regfile_weW}, 32'd1);
    check("alu.addr_lit", {27'd0, writeRegAddrW}, 32'd5);
    check("alu.data_lit", writeDataW, 32'h1234_5678);
    check("alu.count_lit", retireCountW, 32'd1);

    // Loads from a single memory word
    drive(1, 1, 5'd6, 2'b01, 3'd3, 32'h1000_0000, LOAD_WORD, 32'h0, 0, 0);
    cycle(); check_all("lb0");  check("lb0.lit", writeDataW, 32'h0000_0001);
    drive(1, 1, 5'd6, 2'b01, 3'd3, 32'h1000_0002, LOAD_WORD, 32'h0, 0, 0);
    cycle(); check_all("lb2");  check("lb2.lit", writeDataW, 32'hFFFF_FFFF);
    drive(1, 1, 5'd6, 2'b01, 3'd4, 32'h1000_0003, LOAD_WORD, 32'h0, 0, 0);
    cycle(); check_all("lbu3"); check("lbu3.lit", writeDataW, 32'h0000_0080);
    drive(1, 1, 5'd6, 2'b01, 3'd1, 32'h1000_0002, LOAD_WORD, 32'h0, 0, 0);
    cycle(); check_all("lh2");  check("lh2.lit", writeDataW, 32'hFFFF_80FF);
    drive(1, 1, 5'd6, 2'b01, 3'd2, 32'h1000_0000, LOAD_WORD, 32'h0, 0, 0);
    cycle(); check_all("lhu0"); check("lhu0.lit", writeDataW, 32'h0000_7F01);

    // r0 never written; link value selected
    drive(1, 1, 5'd0, 2'b00, 3'd0, 32'hAAAA_5555, 32'h0, 32'h0, 0, 0);
    cycle(); check_all("r0"); check("r0.we_lit", {31'd0, Regfile_weW}, 32'd0);
    drive(1, 1, 5'd31, 2'b10, 3'd0, 32'h5555_AAAA, 32'h0, 32'h0040_0008, 0, 0);
    cycle(); check_all("link"); check("link.data_lit", writeDataW, 32'h0040_0008);
    check("link.count_lit", retireCountW, 32'd8);

    // Stall three cycles with fresh valid traffic on the M side
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'd9, 2'b00, 3'd0, 32'h9999_0000 + i, 32'h0, 32'h0, 1, 0);
      cycle();
      check_all("stall");
      check("stall.data_lit", writeDataW, 32'h0040_0008);
      check("stall.count_lit", retireCountW, 32'd8);
    end

    // Flush and stall together: bubble wins, counter untouched
    drive(1, 1, 5'd9, 2'b00, 3'd0, 32'h7777_7777, 32'h0, 32'h0, 1, 1);
    cycle(); check_all("flush_stall");
    check("flush_stall.valid_lit", {31'd0, validW}, 32'd0);
    check("flush_stall.we_lit", {31'd0, Regfile_weW}, 32'd0);
    check("flush_stall.data_lit", writeDataW, 32'd0);
    check("flush_stall.count_lit", retireCountW, 32'd8);

    // Reload a real instruction, then reset asynchronously mid-cycle
    drive(1, 1, 5'd3, 2'b00, 3'd0, 32'h0BAD_F00D, 32'h0, 32'h0, 0, 0);
    cycle(); check_all("pre_areset");
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    check("areset.data_lit", writeDataW, 32'd0);
    check("areset.valid_lit", {31'd0, validW}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 5'd4, 2'b00, 3'd0, 32'h1111_1111, 32'h0, 32'h0, 0, 0);
    cycle(); check_all("post_reset_bubble");

    // Sixteen accepted instructions wrap the 4-bit counter to 0
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 5'(i + 1), 2'b00, 3'd0, 32'(i), 32'h0, 32'h0, 0, 0);
      cycle();
    end
    check_all("wrap");
    check("wrap.cnt4_lit", {28'd0, s_count}, 32'd0);
    check("wrap.count_lit", retireCountW, 32'd16);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      cycle();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
